jpeg_bit_packer: RTL and testbench

Packs the variable-length Huffman codewords produced by the JPEG coder into a byte-aligned JPEG entropy-coded bitstream. It inserts the mandatory 0x00 stuffing byte after every 0xFF data byte. On end-of-image it pads the final partial byte with 1s and appends the EOI marker (0xFF 0xD9). The block sits directly downstream of the coder's Huffman output and feeds a byte-wide sink (DMA/FIFO) through a valid/ready handshake.

---
 rtl/jpeg_bit_packer_if.sv | 30 +++
 rtl/jpeg_bit_packer.sv | 162 ++++++++++++++++
 tb/tb_jpeg_bit_packer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_bit_packer_if.sv
// jpeg_bit_packer_if
//   Bundles the codeword input stream and the byte output stream of the
//   JPEG bit packer.
//   Codeword side : in_valid, in_ready, in_code[CODE_W], in_len[6], in_flush
//   Byte side     : out_valid, out_ready, out_data[8], out_last
//   master : the environment (Huffman coder upstream plus byte sink downstream)
//   slave  : the packer itself
interface jpeg_bit_packer_if #(
    parameter int CODE_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic [5:0]        in_len;
    logic              in_flush;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;

    modport master (
        output in_valid, in_code, in_len, in_flush, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_code, in_len, in_flush, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer
//   Packs variable-length Huffman codewords into a byte-aligned JPEG
//   entropy-coded stream. Inserts a 0x00 stuffing byte after every 0xFF data
//   byte. On end-of-image it pads the last partial byte with 1s and appends
//   the EOI marker 0xFF 0xD9.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : jpeg_bit_packer_if.slave (codeword in, byte out, valid/ready)
//   Parameters:
//     CODE_W : maximum codeword length (in_len 0..CODE_W)
//     ACC_W  : bit accumulator width, must be >= CODE_W + 8
module jpeg_bit_packer #(
    parameter int CODE_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    jpeg_bit_packer_if.slave  bus
);
    localparam int CNT_W = $clog2(ACC_W + 1);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] STUFF  = 2'd1;
    localparam logic [1:0] EOI_FF = 2'd2;
    localparam logic [1:0] EOI_D9 = 2'd3;

    localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ACC_W - CODE_W);

    // Valid bits are left-aligned in acc_q; the top byte is always next out.
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic [1:0]       state_q, state_d;

    logic [7:0]       top_byte;
    logic [7:0]       pad_byte;
    logic [CODE_W-1:0] code_mask;
    logic [ACC_W-1:0] code_ext;
    logic             out_valid_s;
    logic [7:0]       out_data_s;
    logic             fire_out;
    logic             accept;

    // Scratch values for the RUN-state append (after same-cycle byte removal).
    logic [ACC_W-1:0] acc_rm;
    logic [CNT_W-1:0] cnt_rm;
    logic [CNT_W-1:0] shamt;

    assign top_byte  = acc_q[ACC_W-1 -: 8];
    // 1-bits filling the free low part of the top byte when flushing.
    assign pad_byte  = 8'hFF >> cnt_q[2:0];
    assign code_mask = ~({CODE_W{1'b1}} << bus.in_len);
    assign code_ext  = {{(ACC_W-CODE_W){1'b0}}, bus.in_code & code_mask};

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        out_valid_s = 1'b0;
        out_data_s  = 8'h00;
        case (state_q)
            RUN: begin
                out_valid_s = (cnt_q >= BYTE_BITS);
                out_data_s  = top_byte;
            end
            STUFF: begin
                out_valid_s = 1'b1;
                out_data_s  = 8'h00;
            end
            EOI_FF: begin
                out_valid_s = 1'b1;
                out_data_s  = 8'hFF;
            end
            EOI_D9: begin
                out_valid_s = 1'b1;
                out_data_s  = 8'hD9;
            end
            default: begin
                out_valid_s = 1'b0;
                out_data_s  = 8'h00;
            end
        endcase
    end

    // Outputs are forced idle while reset is held, even before the first edge.
    assign bus.out_valid = !rst && out_valid_s;
    assign bus.out_data  = rst ? 8'h00 : out_data_s;
    assign bus.out_last  = !rst && (state_q == EOI_D9);
    // Guarantees a full CODE_W codeword always fits, whatever in_len is.
    assign bus.in_ready  = !rst && (state_q == RUN) && !flush_pend_q && (cnt_q <= READY_MAX);

    assign fire_out = bus.out_valid && bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        state_d      = state_q;
        acc_rm       = acc_q;
        cnt_rm       = cnt_q;
        shamt        = '0;

        case (state_q)
            RUN: begin
                // Byte removal happens before the append in the same cycle.
                if (fire_out) begin
                    acc_rm = acc_q << 8;
                    cnt_rm = cnt_q - BYTE_BITS;
                    if (top_byte == 8'hFF) state_d = STUFF;
                end
                acc_d = acc_rm;
                cnt_d = cnt_rm;
                if (accept) begin
                    shamt = CNT_W'(ACC_W) - cnt_rm - CNT_W'(bus.in_len);
                    acc_d = acc_rm | (code_ext << shamt);
                    cnt_d = cnt_rm + CNT_W'(bus.in_len);
                    if (bus.in_flush) flush_pend_d = 1'b1;
                end
                // Flush only acts once the partial byte is the only thing left.
                if (flush_pend_q && (cnt_q < BYTE_BITS)) begin
                    if (cnt_q == '0) begin
                        state_d = EOI_FF;
                    end else begin
                        acc_d = acc_q | {pad_byte, {(ACC_W-8){1'b0}}};
                        cnt_d = BYTE_BITS;
                    end
                end
            end
            STUFF: begin
                if (fire_out) state_d = RUN;
            end
            EOI_FF: begin
                if (fire_out) state_d = EOI_D9;
            end
            EOI_D9: begin
                if (fire_out) begin
                    state_d      = RUN;
                    flush_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            state_q      <= RUN;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            state_q      <= state_d;
        end
    end
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer
//   Self-checking bench for jpeg_bit_packer. Stimulus pushes the expected
//   byte stream into a scoreboard queue through a bit-level reference model;
//   an independent monitor pops and compares each byte the packer hands out.
module tb_jpeg_bit_packer;
    localparam int CODE_W = 32;
    localparam int ACC_W  = 64;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       stuff;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jpeg_bit_packer_if #(.CODE_W(CODE_W)) bus_if ();

    jpeg_bit_packer #(.CODE_W(CODE_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t exp_q[$];
    bit   bits_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   ready_mode = 0;  // 0 always ready, 1 random, 2 stalled, 3 one beat then stalled

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Reference model: the stream is a plain queue of bits, cut into bytes.
    function automatic void model_emit_bytes();
        logic [7:0] b;
        while (bits_q.size() >= 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], bits_q.pop_front()};
            exp_q.push_back('{b, 1'b0, 1'b0});
            if (b == 8'hFF) exp_q.push_back('{8'h00, 1'b0, 1'b1});
        end
    endfunction

    function automatic void model_accept(input logic [31:0] code, input int len, input bit flush);
        for (int i = len - 1; i >= 0; i--) bits_q.push_back(code[i]);
        model_emit_bytes();
        if (flush) begin
            while (bits_q.size() % 8 != 0) bits_q.push_back(1'b1);
            model_emit_bytes();
            exp_q.push_back('{8'hFF, 1'b0, 1'b0});
            exp_q.push_back('{8'hD9, 1'b1, 1'b0});
        end
    endfunction

    // Called at a negedge; offers a codeword for one cycle, returns at the next negedge.
    task automatic try_cycle(input logic [31:0] code, input int len, input bit flush, output bit acc);
        bus_if.in_valid = 1'b1;
        bus_if.in_code  = code;
        bus_if.in_len   = 6'(len);
        bus_if.in_flush = flush;
        #1;
        acc = bus_if.in_ready;
        if (acc) model_accept(code, len, flush);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.in_flush = 1'b0;
    endtask

    task automatic send(input logic [31:0] code, input int len, input bit flush);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 1000) begin
            try_cycle(code, len, flush, acc);
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: code 0x%0h not accepted in %0d cycles", code, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        ready_mode = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("idle_out_valid", bus_if.out_valid, 1'b0);
    endtask

    // Monitor: drives the sink side and checks every handshaken byte.
    initial begin
        bus_if.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: bus_if.out_ready = 1'b1;
                1: bus_if.out_ready = 1'($urandom_range(0, 1));
                2: bus_if.out_ready = 1'b0;
                default: begin
                    bus_if.out_ready = 1'b1;
                    ready_mode = 2;
                end
            endcase
            if (!rst && bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%0h want no byte", bus_if.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", bus_if.out_data, mon_e.data);
                    check("out_last", bus_if.out_last, mon_e.last);
                    if (mon_e.stuff) check("in_ready_in_stuff", bus_if.in_ready, 1'b0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        logic [7:0] held;
        int         len;
        bus_if.in_valid = 1'b0;
        bus_if.in_code  = '0;
        bus_if.in_len   = '0;
        bus_if.in_flush = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus_if.out_valid, 1'b0);
        check("rst_out_data",  bus_if.out_data,  8'h00);
        check("rst_out_last",  bus_if.out_last,  1'b0);
        check("rst_in_ready",  bus_if.in_ready,  1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus_if.in_ready, 1'b1);
        @(negedge clk);

        // Single byte with one-cycle latency, then idle
        ready_mode = 0;
        send(32'h0000_00A5, 8, 1'b0);
        check("single_latency_valid", bus_if.out_valid, 1'b1);
        @(negedge clk);
        check("single_then_idle", bus_if.out_valid, 1'b0);
        drain();

        // Concatenation with garbage above in_len
        send(32'hFFFF_FFF5, 3, 1'b0);
        send(32'hABCD_EF13, 5, 1'b0);
        drain();

        // Stuffing
        send(32'h0000_00FF, 8, 1'b0);
        send(32'h0000_0012, 8, 1'b0);
        drain();

        // Flush with partial byte, flush whose pad yields 0xFF, flush on empty
        send(32'h0000_0005, 4, 1'b1);
        drain();
        send(32'h0000_000F, 4, 1'b1);
        drain();
        send(32'h0000_0000, 0, 1'b1);
        drain();

        // Backpressure: random sink, then a hard stall
        ready_mode = 1;
        for (int i = 0; i < 16; i++) send(32'hDEAD_BEEF, 32, 1'b0);
        ready_mode = 2;
        held = 8'h00;
        for (int i = 0; i < 20; i++) begin
            try_cycle(32'hDEAD_BEEF, 32, 1'b0, acc);
            if (i == 0) begin
                held = bus_if.out_data;
            end else begin
                check("stall_out_valid", bus_if.out_valid, 1'b1);
                check("stall_out_data",  bus_if.out_data,  held);
            end
        end
        check("stall_in_ready", bus_if.in_ready, 1'b0);
        drain();

        // Random codewords, lengths 0..CODE_W, occasional flush, random sink
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            len = int'($urandom_range(0, CODE_W));
            send($urandom, len, ($urandom_range(0, 19) == 0));
        end
        send(32'h0, 0, 1'b1);
        drain();

        // Reset while a stuffing byte is pending and 13 bits are buffered
        ready_mode = 2;
        send(32'h0000_00FF, 8, 1'b0);
        send(32'h0000_00AA, 8, 1'b0);
        send(32'h0000_0015, 5, 1'b0);
        ready_mode = 3;
        wait (ready_mode == 2);
        @(negedge clk);
        check("pre_rst_stuff_valid", bus_if.out_valid, 1'b1);
        check("pre_rst_stuff_data",  bus_if.out_data,  8'h00);
        rst = 1'b1;
        exp_q.delete();
        bits_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", bus_if.out_valid, 1'b0);
        check("mid_rst_in_ready",  bus_if.in_ready,  1'b0);
        check("mid_rst_out_last",  bus_if.out_last,  1'b0);
        rst = 1'b0;
        #1;
        check("after_rst_in_ready", bus_if.in_ready, 1'b1);
        @(negedge clk);
        ready_mode = 0;
        send(32'h0000_003C, 8, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
